// File: rtl/cpu_param_if.sv
// Opcode package and CPU bus interface.
// The package holds the opcode encodings shared by the core and anything that builds programs for it.
// Bus: addr/dout/re/we are driven by the core, di/rdy by memory; one transfer completes per edge with rdy=1 and re or we high.
package cpu_param_pkg;
    localparam logic [7:0] OP_HALT = 8'h00;
    localparam logic [7:0] OP_LD   = 8'h01;
    localparam logic [7:0] OP_ST   = 8'h02;
    localparam logic [7:0] OP_LDI  = 8'h03;
    localparam logic [7:0] OP_MOV  = 8'h04;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_SUB  = 8'h06;
    localparam logic [7:0] OP_AND  = 8'h07;
    localparam logic [7:0] OP_OR   = 8'h08;
    localparam logic [7:0] OP_XOR  = 8'h09;
    localparam logic [7:0] OP_ROTL = 8'h0A;
    localparam logic [7:0] OP_ROTR = 8'h0B;
    localparam logic [7:0] OP_JMP  = 8'h0C;
    localparam logic [7:0] OP_BZ   = 8'h0D;
    localparam logic [7:0] OP_BNZ  = 8'h0E;
endpackage

interface cpu_param_if #(
    parameter int DW = 8,
    parameter int AW = 16
) ();
    logic [AW-1:0] addr;   // bus address
    logic [DW-1:0] di;     // read data (instruction bytes on di[7:0])
    logic [DW-1:0] dout;   // write data ("do")
    logic          re;     // read request
    logic          we;     // write request
    logic          rdy;    // completion strobe

    modport master (output addr, dout, re, we, input di, rdy);
    modport slave  (input addr, dout, re, we, output di, rdy);
endinterface

// File: rtl/cpu_param.sv
// Parameterised multi-cycle CPU: FETCH(4 bytes) -> DECODE -> [MEM for LD/ST] -> EXECUTE.
// Latency: 6 cycles per instruction, 7 for LD/ST, with rdy tied high; each wait cycle adds one.
// Backpressure: rdy=0 stalls with addr/re/we/dout held; wait states are unbounded.
// Ports: clk, rst (sync, active high), bus (cpu_param_if.master), halted.
// Option: define CPU_BRANCH_EN to add Z/C flags and the BZ/BNZ branches.
module cpu_param
    import cpu_param_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 16,
    parameter int AW   = 16
) (
    input  logic        clk,
    input  logic        rst,
    cpu_param_if.master bus,
    output logic        halted
);
    localparam int IW = $clog2(NREG);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXECUTE,
        S_HALTED
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    cnt, cnt_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW-1:0] addr_q, addr_nxt;
    logic          re_q, re_nxt;
    logic          we_q, we_nxt;
    logic [DW-1:0] dout_q, dout_nxt;
    logic          halted_q, halted_nxt;
    logic [31:0]   ir, ir_nxt;
    logic [DW-1:0] mdata, mdata_nxt;

`ifdef CPU_BRANCH_EN
    logic z_flag, z_nxt;
    logic c_flag, c_nxt;
`endif

    // Register file is deliberately not reset.
    logic [DW-1:0] regs [NREG];
    logic          rf_we;
    logic [IW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    // Instruction fields, opcode in the first fetched byte.
    logic [7:0] op, fd, fa, fb;
    assign op = ir[31:24];
    assign fd = ir[23:16];
    assign fa = ir[15:8];
    assign fb = ir[7:0];

    logic [DW-1:0] ra, rb, rd;
    assign ra = regs[fa[IW-1:0]];
    assign rb = regs[fb[IW-1:0]];
    assign rd = regs[fd[IW-1:0]];

    logic [AW-1:0] daddr, tgt, pc4;
    assign daddr = AW'({fa, fb});
    assign tgt   = AW'({fd, fa});
    assign pc4   = pc + AW'(4);

    // ALU datapath; the extra top bit of sum/diff is carry/borrow.
    logic [DW:0]     sum, diff;
    logic [5:0]      sh;
    logic [2*DW-1:0] rl, rr;
    assign sum  = {1'b0, ra} + {1'b0, rb};
    assign diff = {1'b0, ra} - {1'b0, rb};
    assign sh   = 6'(rb % DW);
    // Rotating the doubled word lets a plain shift act as a rotate for any DW.
    assign rl   = {ra, ra} << sh;
    assign rr   = {ra, ra} >> sh;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        pc_nxt     = pc;
        addr_nxt   = addr_q;
        re_nxt     = re_q;
        we_nxt     = we_q;
        dout_nxt   = dout_q;
        halted_nxt = halted_q;
        ir_nxt     = ir;
        mdata_nxt  = mdata;
        rf_we      = 1'b0;
        rf_wa      = fd[IW-1:0];
        rf_wd      = ra;
`ifdef CPU_BRANCH_EN
        z_nxt      = z_flag;
        c_nxt      = c_flag;
`endif
        case (state)
            S_FETCH: begin
                if (!re_q) begin
                    // Only reachable straight after reset: start the first fetch.
                    re_nxt   = 1'b1;
                    addr_nxt = pc + AW'(cnt);
                end else if (bus.rdy) begin
                    // Bytes shift in from the bottom, so the first lands in ir[31:24].
                    ir_nxt  = {ir[23:0], bus.di[7:0]};
                    cnt_nxt = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        re_nxt    = 1'b0;
                        state_nxt = S_DECODE;
                    end else begin
                        addr_nxt = pc + AW'(cnt_nxt);
                    end
                end
            end
            S_DECODE: begin
                case (op)
                    OP_HALT: begin
                        state_nxt  = S_HALTED;
                        halted_nxt = 1'b1;
                    end
                    OP_LD: begin
                        re_nxt    = 1'b1;
                        addr_nxt  = daddr;
                        state_nxt = S_MEM;
                    end
                    OP_ST: begin
                        we_nxt    = 1'b1;
                        addr_nxt  = daddr;
                        dout_nxt  = rd;
                        state_nxt = S_MEM;
                    end
                    default: state_nxt = S_EXECUTE;
                endcase
            end
            S_MEM: begin
                if (bus.rdy) begin
                    re_nxt    = 1'b0;
                    we_nxt    = 1'b0;
                    mdata_nxt = bus.di;
                    state_nxt = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                pc_nxt = pc4;
                case (op)
                    OP_LD:  begin rf_we = 1'b1; rf_wd = mdata; end
                    OP_LDI: begin rf_we = 1'b1; rf_wd = DW'(fa); end
                    OP_MOV: begin rf_we = 1'b1; rf_wd = ra; end
                    OP_ADD: begin
                        rf_we = 1'b1;
                        rf_wd = sum[DW-1:0];
`ifdef CPU_BRANCH_EN
                        z_nxt = (sum[DW-1:0] == '0);
                        c_nxt = sum[DW];
`endif
                    end
                    OP_SUB: begin
                        rf_we = 1'b1;
                        rf_wd = diff[DW-1:0];
`ifdef CPU_BRANCH_EN
                        z_nxt = (diff[DW-1:0] == '0);
                        c_nxt = diff[DW];
`endif
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        rf_we = 1'b1;
                        if (op == OP_AND)     rf_wd = ra & rb;
                        else if (op == OP_OR) rf_wd = ra | rb;
                        else                  rf_wd = ra ^ rb;
`ifdef CPU_BRANCH_EN
                        z_nxt = (rf_wd == '0);
                        c_nxt = 1'b0;
`endif
                    end
                    OP_ROTL: begin rf_we = 1'b1; rf_wd = rl[2*DW-1:DW]; end
                    OP_ROTR: begin rf_we = 1'b1; rf_wd = rr[DW-1:0]; end
                    OP_JMP:  pc_nxt = tgt;
`ifdef CPU_BRANCH_EN
                    OP_BZ:   if (z_flag)  pc_nxt = tgt;
                    OP_BNZ:  if (!z_flag) pc_nxt = tgt;
`else
                    OP_BZ, OP_BNZ: pc_nxt = pc4;
`endif
                    default: ;
                endcase
                // Launch the next fetch now so the first byte can complete next edge.
                re_nxt    = 1'b1;
                addr_nxt  = pc_nxt;
                cnt_nxt   = 2'd0;
                state_nxt = S_FETCH;
            end
            S_HALTED: begin
                re_nxt     = 1'b0;
                we_nxt     = 1'b0;
                halted_nxt = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            cnt      <= '0;
            pc       <= '0;
            addr_q   <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
            dout_q   <= '0;
            halted_q <= 1'b0;
            ir       <= '0;
            mdata    <= '0;
`ifdef CPU_BRANCH_EN
            z_flag   <= 1'b0;
            c_flag   <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pc       <= pc_nxt;
            addr_q   <= addr_nxt;
            re_q     <= re_nxt;
            we_q     <= we_nxt;
            dout_q   <= dout_nxt;
            halted_q <= halted_nxt;
            ir       <= ir_nxt;
            mdata    <= mdata_nxt;
`ifdef CPU_BRANCH_EN
            z_flag   <= z_nxt;
            c_flag   <= c_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rf_we) begin
            regs[rf_wa] <= rf_wd;
        end
    end

    assign bus.addr = addr_q;
    assign bus.re   = re_q;
    assign bus.we   = we_q;
    assign bus.dout = dout_q;
    assign halted   = halted_q;
endmodule
